// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage external SRAM access controller:
// memory-op codes, stall levels and the wait-counter width.
package mem_access_ctrl_pkg;

  localparam int MEM_OP_W    = 2;
  localparam int SRAM_ADDR_W = 18;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP   = 2'b00,
    MEM_OP_READ  = 2'b01,
    MEM_OP_WRITE = 2'b10,
    MEM_OP_RSVD  = 2'b11
  } mem_op_e;

  localparam logic STALL_ENABLE  = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;

  // The reserved code 11 behaves as a NOP.
  function automatic logic is_mem_access(input mem_op_e op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times SRAM access and write-strobe phases.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  dec_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WAIT_CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: runs multi-cycle reads/writes on an asynchronous SRAM,
// stalls the pipeline while busy and returns registered load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [15:0]         mem_addr,
  input  logic [DATA_W-1:0]   RAM_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                mem_stall,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACCESS,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic                busy;
  logic                cnt_load, cnt_dec, cnt_zero;
  mem_op_e             op;

  assign op = mem_op_e'(mem_op);

  mem_wait_counter u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .load_val_i(WAIT_LOAD),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    busy     = STALL_DISABLE;

    unique case (state_q)
      ST_IDLE: begin
        busy = is_mem_access(op) ? STALL_ENABLE : STALL_DISABLE;
        if (op == MEM_OP_READ) begin
          addr_d   = ADDR_W'(mem_addr);
          cnt_load = 1'b1;
          state_d  = ST_RD_ACCESS;
        end else if (op == MEM_OP_WRITE) begin
          addr_d  = ADDR_W'(mem_addr);
          wdata_d = RAM_data;
          state_d = ST_WR_SETUP;
        end
      end
      ST_RD_ACCESS: begin
        busy = STALL_ENABLE;
        if (cnt_zero) begin
          rdata_d = sram_dq_i;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        busy     = STALL_ENABLE;
        cnt_load = 1'b1;
        state_d  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        busy = STALL_ENABLE;
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        busy    = STALL_ENABLE;
        state_d = ST_DONE;
      end
      // The pipeline advances at the end of DONE, so mem_op here still belongs
      // to the finished instruction and must not be sampled.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to.
    ce_n_d  = !(state_d inside {ST_RD_ACCESS, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    oe_n_d  = (state_d != ST_RD_ACCESS);
    we_n_d  = (state_d != ST_WR_PULSE);
    dq_oe_d = (state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  // Held low during reset so a frozen pipeline is released immediately.
  assign mem_stall  = busy & ~rst;
  assign read_data  = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES=1 and 3) driven by
// directed vectors, hand-built corner sequences and random ops vs. a timing model.
module tb_mem_access_ctrl;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int WAITS [2] = '{1, 3};

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    op_a   [2];
  logic [15:0]   addr_a [2];
  logic [DW-1:0] wd_a   [2];
  logic [DW-1:0] rd_a   [2];
  logic [DW-1:0] dqo_a  [2];
  logic [AW-1:0] sa_a   [2];
  logic          stall_a[2];
  logic          dqoe_a [2];
  logic          cen_a  [2];
  logic          oen_a  [2];
  logic          wen_a  [2];
  logic [DW-1:0] dqi_0, dqi_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Read-only SRAM contents as a function of the address on the pins.
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    if (a == 18'h01234) return 16'hBEEF;
    return 16'(a * 18'h009E3) ^ 16'h5A5A;
  endfunction

  assign dqi_0 = rom_f(sa_a[0]);
  assign dqi_1 = rom_f(sa_a[1]);

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .mem_op(op_a[0]), .mem_addr(addr_a[0]), .RAM_data(wd_a[0]),
    .read_data(rd_a[0]), .mem_stall(stall_a[0]), .sram_addr(sa_a[0]), .sram_dq_o(dqo_a[0]),
    .sram_dq_oe(dqoe_a[0]), .sram_dq_i(dqi_0), .sram_ce_n(cen_a[0]), .sram_oe_n(oen_a[0]),
    .sram_we_n(wen_a[0])
  );

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .mem_op(op_a[1]), .mem_addr(addr_a[1]), .RAM_data(wd_a[1]),
    .read_data(rd_a[1]), .mem_stall(stall_a[1]), .sram_addr(sa_a[1]), .sram_dq_o(dqo_a[1]),
    .sram_dq_oe(dqoe_a[1]), .sram_dq_i(dqi_1), .sram_ce_n(cen_a[1]), .sram_oe_n(oen_a[1]),
    .sram_we_n(wen_a[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs(input logic s);
    return {9'd0, stall_a[s], cen_a[s], oen_a[s], wen_a[s], dqoe_a[s], sa_a[s], dqo_a[s], rd_a[s]};
  endfunction

  function automatic logic [63:0] expv(input logic st, input logic ce, input logic oe,
                                       input logic we, input logic dqoe, input logic [AW-1:0] a,
                                       input logic [DW-1:0] dq, input logic [DW-1:0] rd);
    return {9'd0, st, ce, oe, we, dqoe, a, dq, rd};
  endfunction

  // One transaction per row: counts are cycles from the accepting IDLE cycle
  // through DONE; strobe counts exclude nothing, so DONE must be quiet.
  typedef struct {
    logic          sel;
    logic [1:0]    op;
    logic [15:0]   addr;
    logic [15:0]   wdata;
    logic          scramble;
    int            exp_stall;
    int            exp_ce;
    int            exp_oe;
    int            exp_we;
    int            exp_dqoe;
    logic [15:0]   exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic run_txn(input vec_t v, input int idx);
    logic          s = v.sel;
    int            n_stall = 0, n_ce = 0, n_oe = 0, n_we = 0, n_dqoe = 0;
    int            bad_addr = 0, bad_dq = 0, hazard = 0;
    logic          done = 1'b0;
    logic          prev_dqoe = dqoe_a[s];
    logic [DW-1:0] rd_done = '0;
    op_a[s]   = v.op;
    addr_a[s] = v.addr;
    wd_a[s]   = v.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (stall_a[s]) n_stall++;
      else begin
        done    = 1'b1;
        rd_done = rd_a[s];
      end
      if (!cen_a[s]) begin
        n_ce++;
        if (sa_a[s] !== AW'(v.addr)) bad_addr++;
      end
      if (!oen_a[s]) n_oe++;
      if (!wen_a[s]) n_we++;
      if (dqoe_a[s]) begin
        n_dqoe++;
        if (dqo_a[s] !== v.wdata) bad_dq++;
      end
      if (!oen_a[s] && dqoe_a[s]) hazard++;
      if (!wen_a[s] && (dqoe_a[s] !== prev_dqoe)) hazard++;
      prev_dqoe = dqoe_a[s];
      @(posedge clk);
      #1;
      if (cyc == 0 && v.scramble) begin
        addr_a[s] = 16'h0000;
        wd_a[s]   = 16'h0000;
      end
      if (done) op_a[s] = OP_NOP;
    end
    check($sformatf("row%0d reached_done", idx), 64'(done), 64'(1));
    check($sformatf("row%0d stall_cycles", idx), 64'(n_stall), 64'(v.exp_stall));
    check($sformatf("row%0d ce_low_cycles", idx), 64'(n_ce), 64'(v.exp_ce));
    check($sformatf("row%0d oe_low_cycles", idx), 64'(n_oe), 64'(v.exp_oe));
    check($sformatf("row%0d we_low_cycles", idx), 64'(n_we), 64'(v.exp_we));
    check($sformatf("row%0d dq_oe_cycles", idx), 64'(n_dqoe), 64'(v.exp_dqoe));
    check($sformatf("row%0d read_data", idx), 64'(rd_done), 64'(v.exp_rd));
    check($sformatf("row%0d addr_unstable", idx), 64'(bad_addr), 64'(0));
    check($sformatf("row%0d wdata_unstable", idx), 64'(bad_dq), 64'(0));
    check($sformatf("row%0d bus_hazard", idx), 64'(hazard), 64'(0));
  endtask

  // Back-to-back and random-phase scratch state (used by the main process only).
  logic [1:0]    seq_op [9];
  logic [8:0]    got_stall, got_oe, got_we, got_dqoe, got_ce;
  int            act_cnt;
  logic          rs;
  int            r_w, r_k;
  logic          e_st, e_ce, e_oe, e_we, e_dqoe, e_fin;
  logic          m_busy [2];
  logic          m_write[2];
  int            m_t0   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata[2];
  logic [DW-1:0] m_rd   [2];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, OP_RD, 16'h1234, 16'h0000, 1'b0, 2, 1, 1, 0, 0, 16'hBEEF};
    vecs[1] = '{1'b1, OP_WR, 16'hFFFF, 16'hA5A5, 1'b1, 6, 5, 0, 3, 5, 16'h0000};
    vecs[2] = '{1'b1, OP_RD, 16'h1234, 16'h0000, 1'b0, 4, 3, 3, 0, 0, 16'hBEEF};
    vecs[3] = '{1'b0, OP_WR, 16'h0000, 16'h1234, 1'b0, 4, 3, 0, 1, 3, 16'hBEEF};
    vecs[4] = '{1'b1, OP_RD, 16'h00FF, 16'h0000, 1'b0, 4, 3, 3, 0, 0, rom_f(18'h000FF)};
    vecs[5] = '{1'b0, OP_RD, 16'hFFFF, 16'h0000, 1'b0, 2, 1, 1, 0, 0, rom_f(18'h0FFFF)};
    seq_op  = '{OP_RD, OP_RD, OP_RD, OP_WR, OP_WR, OP_WR, OP_WR, OP_WR, OP_NOP};

    // Reset state, with a READ presented to show the stall is held off.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      op_a[i]   = OP_RD;
      addr_a[i] = 16'h5555;
      wd_a[i]   = 16'h5555;
    end
    @(negedge clk);
    check("reset w1 outputs", obs(1'b0), expv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
    check("reset w3 outputs", obs(1'b1), expv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
    @(posedge clk);
    #1;
    op_a[0] = OP_NOP;
    op_a[1] = OP_NOP;
    rst     = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // READ then WRITE on WAIT_CYCLES=1; READ is still on mem_op during DONE.
    for (int c = 0; c < 9; c++) begin
      op_a[0]   = seq_op[c];
      addr_a[0] = (c < 3) ? 16'h0042 : 16'h0100;
      wd_a[0]   = 16'h7E7E;
      @(negedge clk);
      got_stall[c] = stall_a[0];
      got_oe[c]    = !oen_a[0];
      got_we[c]    = !wen_a[0];
      got_dqoe[c]  = dqoe_a[0];
      got_ce[c]    = !cen_a[0];
      if (c == 1) check("b2b read sram_addr", 64'(sa_a[0]), 64'(18'h00042));
      if (c == 2) check("b2b read_data in DONE", 64'(rd_a[0]), 64'(rom_f(18'h00042)));
      if (c == 5) begin
        check("b2b write sram_addr", 64'(sa_a[0]), 64'(18'h00100));
        check("b2b write dq_o", 64'(dqo_a[0]), 64'(16'h7E7E));
      end
      if (c == 8) check("b2b read_data kept", 64'(rd_a[0]), 64'(rom_f(18'h00042)));
      @(posedge clk);
      #1;
    end
    check("b2b stall pattern", 64'(got_stall), 64'(9'b001111011));
    check("b2b oe_n low pattern", 64'(got_oe), 64'(9'b000000010));
    check("b2b we_n low pattern", 64'(got_we), 64'(9'b000100000));
    check("b2b dq_oe pattern", 64'(got_dqoe), 64'(9'b001110000));
    check("b2b ce_n low pattern", 64'(got_ce), 64'(9'b001110010));

    // Reserved op code behaves as NOP.
    act_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      op_a[1]   = OP_BAD;
      addr_a[1] = 16'($urandom);
      wd_a[1]   = 16'($urandom);
      @(negedge clk);
      if (stall_a[1] || !cen_a[1] || !oen_a[1] || !wen_a[1] || dqoe_a[1]) act_cnt++;
      @(posedge clk);
      #1;
    end
    op_a[1] = OP_NOP;
    check("illegal_op active_cycles", 64'(act_cnt), 64'(0));
    check("illegal_op read_data", 64'(rd_a[1]), 64'(rom_f(18'h000FF)));

    // Asynchronous reset in the middle of the write pulse.
    op_a[1]   = OP_WR;
    addr_a[1] = 16'h2222;
    wd_a[1]   = 16'h3333;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid we_n before", 64'(wen_a[1]), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid strobes+stall", 64'({stall_a[1], cen_a[1], oen_a[1], wen_a[1], dqoe_a[1]}),
          64'(5'b01110));
    @(posedge clk);
    #1;
    op_a[0] = OP_NOP;
    op_a[1] = OP_NOP;
    rst     = 1'b0;
    @(negedge clk);
    check("rst_mid w3 idle after", obs(1'b1), expv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
    check("rst_mid w1 idle after", obs(1'b0), expv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0));
    @(posedge clk);
    #1;

    // Random ops on both instances against a transaction-timing model.
    for (int i = 0; i < 2; i++) begin
      m_busy[i]  = 1'b0;
      m_write[i] = 1'b0;
      m_t0[i]    = 0;
      m_addr[i]  = '0;
      m_wdata[i] = '0;
      m_rd[i]    = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        op_a[i]   = 2'($urandom_range(0, 3));
        addr_a[i] = 16'($urandom);
        wd_a[i]   = 16'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        rs     = 1'(i);
        r_w    = WAITS[rs];
        r_k    = c - m_t0[rs];
        e_st   = 1'b0;
        e_ce   = 1'b1;
        e_oe   = 1'b1;
        e_we   = 1'b1;
        e_dqoe = 1'b0;
        e_fin  = 1'b0;
        if (!m_busy[rs]) begin
          e_st = (op_a[rs] == OP_RD) || (op_a[rs] == OP_WR);
        end else if (!m_write[rs]) begin
          if (r_k <= r_w) begin
            e_st = 1'b1;
            e_ce = 1'b0;
            e_oe = 1'b0;
          end else begin
            e_fin    = 1'b1;
            m_rd[rs] = rom_f(m_addr[rs]);
          end
        end else begin
          if (r_k <= r_w + 2) begin
            e_st   = 1'b1;
            e_ce   = 1'b0;
            e_dqoe = 1'b1;
            e_we   = !(r_k >= 2 && r_k <= r_w + 1);
          end else begin
            e_fin = 1'b1;
          end
        end
        check($sformatf("rand cycle%0d wait%0d", c, r_w), obs(rs),
              expv(e_st, e_ce, e_oe, e_we, e_dqoe, m_addr[rs], m_wdata[rs], m_rd[rs]));
        if (e_fin) begin
          m_busy[rs] = 1'b0;
        end else if (!m_busy[rs] && e_st) begin
          m_busy[rs]  = 1'b1;
          m_write[rs] = (op_a[rs] == OP_WR);
          m_t0[rs]    = c;
          m_addr[rs]  = AW'(addr_a[rs]);
          if (op_a[rs] == OP_WR) m_wdata[rs] = wd_a[rs];
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
